qs_srt_bank_scheduler: RTL and testbench

//  Owns the sort-engine bank pool and hands each bank in turn to three agents: filler (input),

---
 rtl/qs_srt_pkg.sv | 21 ++
 rtl/qs_srt_bank_fsm.sv | 42 ++++
 rtl/qs_srt_bank_scheduler.sv | 160 ++++++++++++++++
 tb/tb_qs_srt_bank_scheduler.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qs_srt_pkg.sv
// Shared types for the sort-engine bank scheduler: bank lifecycle states,
// default pool size and element-count width.
package qs_srt_pkg;

  localparam int BANKS_N_DEF = 2;
  localparam int N_W_DEF     = 8;
  localparam int BID_W_DEF   = $clog2(BANKS_N_DEF);

  // A bank moves IDLE -> FILLING -> READY -> SORTING -> SORTED -> DRAINING -> IDLE
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FILLING  = 3'd1,
    READY    = 3'd2,
    SORTING  = 3'd3,
    SORTED   = 3'd4,
    DRAINING = 3'd5
  } bank_state_t;

  typedef logic [BID_W_DEF-1:0] bank_id_t;

endpackage

// File: rtl/qs_srt_bank_fsm.sv
// Lifecycle of one bank. The strobes arrive already qualified for this bank;
// each one only has an effect in the state it leaves from.
module qs_srt_bank_fsm
  import qs_srt_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        fill_gnt_i,
  input  logic        fill_done_i,
  input  logic        sort_gnt_i,
  input  logic        sort_emit_i,
  input  logic        drain_gnt_i,
  input  logic        drain_done_i,
  output bank_state_t state_o
);

  bank_state_t state_q;
  bank_state_t state_d;

  // Next-state: advance one step when the strobe matching the current state fires
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (fill_gnt_i)   state_d = FILLING;
      FILLING:  if (fill_done_i)  state_d = READY;
      READY:    if (sort_gnt_i)   state_d = SORTING;
      SORTING:  if (sort_emit_i)  state_d = SORTED;
      SORTED:   if (drain_gnt_i)  state_d = DRAINING;
      DRAINING: if (drain_done_i) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // State register; reset abandons whatever the bank was doing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/qs_srt_bank_scheduler.sv
// Hands banks in strict FIFO order to the filler, the sort core and the
// drainer. Each agent owns one pointer and may have one bank in flight.
// Also holds the element count N of every bank for the core and drainer.
module qs_srt_bank_scheduler
  import qs_srt_pkg::*;
#(
  parameter int BANKS_N = BANKS_N_DEF,
  parameter int N_W     = N_W_DEF,
  localparam int BID_W  = $clog2(BANKS_N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fill_req_i,
  output logic             fill_gnt_o,
  output logic [BID_W-1:0] fill_bank_o,
  input  logic             fill_done_i,
  input  logic [N_W-1:0]   fill_n_i,
  input  logic             sort_await_i,
  output logic             sort_gnt_o,
  output logic [BID_W-1:0] sort_bank_o,
  output logic [N_W-1:0]   sort_n_o,
  input  logic             sort_emit_i,
  input  logic             drain_req_i,
  output logic             drain_gnt_o,
  output logic [BID_W-1:0] drain_bank_o,
  output logic [N_W-1:0]   drain_n_o,
  input  logic             drain_done_i,
  output logic             err_o
);

  bank_state_t      bank_state [BANKS_N];
  logic [N_W-1:0]   n_q        [BANKS_N];

  logic [BID_W-1:0] fill_ptr_q, sort_ptr_q, drain_ptr_q;
  logic             fill_act_q, sort_act_q, drain_act_q;
  logic             fill_gnt_q, sort_gnt_q, drain_gnt_q;
  logic [BID_W-1:0] fill_bank_q, sort_bank_q, drain_bank_q;
  logic [N_W-1:0]   sort_n_q, drain_n_q;
  logic             err_q;

  // Grants: agent idle, request present, and the bank at its pointer is in the source state
  logic fill_go, sort_go, drain_go;
  assign fill_go  = fill_req_i   && !fill_act_q  && (bank_state[fill_ptr_q]  == IDLE);
  assign sort_go  = sort_await_i && !sort_act_q  && (bank_state[sort_ptr_q]  == READY);
  assign drain_go = drain_req_i  && !drain_act_q && (bank_state[drain_ptr_q] == SORTED);

  // Completions only count while the agent actually holds a bank
  logic fill_fin, sort_fin, drain_fin;
  assign fill_fin  = fill_done_i  && fill_act_q;
  assign sort_fin  = sort_emit_i  && sort_act_q;
  assign drain_fin = drain_done_i && drain_act_q;

  genvar gi;
  generate
    for (gi = 0; gi < BANKS_N; gi++) begin : g_bank
      qs_srt_bank_fsm u_fsm (
        .clk          (clk),
        .rst          (rst),
        .fill_gnt_i   (fill_go   && (fill_ptr_q   == BID_W'(gi))),
        .fill_done_i  (fill_fin  && (fill_bank_q  == BID_W'(gi))),
        .sort_gnt_i   (sort_go   && (sort_ptr_q   == BID_W'(gi))),
        .sort_emit_i  (sort_fin  && (sort_bank_q  == BID_W'(gi))),
        .drain_gnt_i  (drain_go  && (drain_ptr_q  == BID_W'(gi))),
        .drain_done_i (drain_fin && (drain_bank_q == BID_W'(gi))),
        .state_o      (bank_state[gi])
      );
    end
  endgenerate

  // Filler agent: pointer, in-flight flag and grant outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_ptr_q  <= '0;
      fill_act_q  <= 1'b0;
      fill_gnt_q  <= 1'b0;
      fill_bank_q <= '0;
    end else begin
      fill_gnt_q <= fill_go;
      if (fill_go) begin
        fill_bank_q <= fill_ptr_q;
        fill_ptr_q  <= fill_ptr_q + BID_W'(1);
        fill_act_q  <= 1'b1;
      end else if (fill_fin) begin
        fill_act_q  <= 1'b0;
      end
    end
  end

  // Sort-core agent: N is loaded with the grant so REG_N is valid in the grant cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sort_ptr_q  <= '0;
      sort_act_q  <= 1'b0;
      sort_gnt_q  <= 1'b0;
      sort_bank_q <= '0;
      sort_n_q    <= '0;
    end else begin
      sort_gnt_q <= sort_go;
      if (sort_go) begin
        sort_bank_q <= sort_ptr_q;
        sort_n_q    <= n_q[sort_ptr_q];
        sort_ptr_q  <= sort_ptr_q + BID_W'(1);
        sort_act_q  <= 1'b1;
      end else if (sort_fin) begin
        sort_act_q  <= 1'b0;
      end
    end
  end

  // Drainer agent: same shape as the sort agent
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_ptr_q  <= '0;
      drain_act_q  <= 1'b0;
      drain_gnt_q  <= 1'b0;
      drain_bank_q <= '0;
      drain_n_q    <= '0;
    end else begin
      drain_gnt_q <= drain_go;
      if (drain_go) begin
        drain_bank_q <= drain_ptr_q;
        drain_n_q    <= n_q[drain_ptr_q];
        drain_ptr_q  <= drain_ptr_q + BID_W'(1);
        drain_act_q  <= 1'b1;
      end else if (drain_fin) begin
        drain_act_q  <= 1'b0;
      end
    end
  end

  // Element counts, captured when the filler finishes a bank
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BANKS_N; i++) n_q[i] <= '0;
    end else if (fill_fin) begin
      n_q[fill_bank_q] <= fill_n_i;
    end
  end

  // Sticky error on any completion strobe from an agent that holds no bank
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((fill_done_i && !fill_act_q) || (sort_emit_i && !sort_act_q) ||
                 (drain_done_i && !drain_act_q)) begin
      err_q <= 1'b1;
    end
  end

  assign fill_gnt_o   = fill_gnt_q;
  assign fill_bank_o  = fill_bank_q;
  assign sort_gnt_o   = sort_gnt_q;
  assign sort_bank_o  = sort_bank_q;
  assign sort_n_o     = sort_n_q;
  assign drain_gnt_o  = drain_gnt_q;
  assign drain_bank_o = drain_bank_q;
  assign drain_n_o    = drain_n_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_qs_srt_bank_scheduler.sv
// Bench for the bank scheduler. The model counts jobs per stage (grants and
// completions per agent); FIFO bank usage means job k lives in bank k mod B.
module tb_qs_srt_bank_scheduler;

  localparam int B  = 2;
  localparam int NW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          fill_req, fill_done, sort_await, sort_emit, drain_req, drain_done;
  logic [NW-1:0] fill_n;
  logic          fill_gnt, sort_gnt, drain_gnt, err;
  logic [0:0]    fill_bank, sort_bank, drain_bank;
  logic [NW-1:0] sort_n, drain_n;

  always #5 clk = ~clk;

  qs_srt_bank_scheduler #(.BANKS_N(B), .N_W(NW)) dut (
    .clk          (clk),
    .rst          (rst),
    .fill_req_i   (fill_req),
    .fill_gnt_o   (fill_gnt),
    .fill_bank_o  (fill_bank),
    .fill_done_i  (fill_done),
    .fill_n_i     (fill_n),
    .sort_await_i (sort_await),
    .sort_gnt_o   (sort_gnt),
    .sort_bank_o  (sort_bank),
    .sort_n_o     (sort_n),
    .sort_emit_i  (sort_emit),
    .drain_req_i  (drain_req),
    .drain_gnt_o  (drain_gnt),
    .drain_bank_o (drain_bank),
    .drain_n_o    (drain_n),
    .drain_done_i (drain_done),
    .err_o        (err)
  );

  int vectors = 0;
  int miscompares = 0;

  // Job counters: grants issued and completions seen, per agent
  int m_f, m_fd, m_s, m_sd, m_d, m_dd;
  int m_n [64];
  int e_fgnt, e_fbank, e_sgnt, e_sbank, e_sn, e_dgnt, e_dbank, e_dn, e_err;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_f = 0; m_fd = 0; m_s = 0; m_sd = 0; m_d = 0; m_dd = 0;
    for (int i = 0; i < 64; i++) m_n[i] = 0;
    e_fgnt = 0; e_fbank = 0; e_sgnt = 0; e_sbank = 0; e_sn = 0;
    e_dgnt = 0; e_dbank = 0; e_dn = 0; e_err = 0;
  endtask

  // One clock edge of the model, using the inputs as they were at the edge
  task automatic model_step();
    bit fg, sg, dg;
    fg = fill_req   && (m_f == m_fd) && ((m_f - m_dd) < B);
    sg = sort_await && (m_s == m_sd) && (m_s < m_fd);
    dg = drain_req  && (m_d == m_dd) && (m_d < m_sd);
    e_fgnt = fg; e_sgnt = sg; e_dgnt = dg;
    if (fg) e_fbank = m_f % B;
    if (sg) begin e_sbank = m_s % B; e_sn = m_n[m_s % 64]; end
    if (dg) begin e_dbank = m_d % B; e_dn = m_n[m_d % 64]; end
    if (fill_done) begin
      if (m_f > m_fd) begin m_n[m_fd % 64] = int'(fill_n); m_fd++; end
      else e_err = 1;
    end
    if (sort_emit) begin
      if (m_s > m_sd) m_sd++;
      else e_err = 1;
    end
    if (drain_done) begin
      if (m_d > m_dd) m_dd++;
      else e_err = 1;
    end
    if (fg) m_f++;
    if (sg) m_s++;
    if (dg) m_d++;
  endtask

  task automatic compare_all();
    check("fill_gnt",   fill_gnt,   e_fgnt);
    check("fill_bank",  fill_bank,  e_fbank);
    check("sort_gnt",   sort_gnt,   e_sgnt);
    check("sort_bank",  sort_bank,  e_sbank);
    check("sort_n",     sort_n,     e_sn);
    check("drain_gnt",  drain_gnt,  e_dgnt);
    check("drain_bank", drain_bank, e_dbank);
    check("drain_n",    drain_n,    e_dn);
    check("err",        err,        e_err);
  endtask

  // Inputs are changed only at the falling edge, between calls
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic clear_inputs();
    fill_req = 0; fill_done = 0; fill_n = '0; sort_await = 0; sort_emit = 0;
    drain_req = 0; drain_done = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    compare_all();
    rst = 0;
  endtask

  task automatic do_fill(input int n, input int exp_bank, input bit immediate);
    int k = 0;
    fill_req = 1;
    tick();
    while (fill_gnt !== 1'b1 && k < 30) begin tick(); k++; end
    check("fill_grant_seen", fill_gnt, 1);
    check("fill_grant_bank", fill_bank, exp_bank);
    if (immediate) check("fill_grant_wait", k, 0);
    fill_req = 0;
    fill_n = n[NW-1:0]; fill_done = 1;
    tick();
    fill_done = 0;
  endtask

  task automatic do_sort(input int exp_bank, input int exp_n);
    int k = 0;
    sort_await = 1;
    tick();
    while (sort_gnt !== 1'b1 && k < 30) begin tick(); k++; end
    check("sort_grant_seen", sort_gnt, 1);
    check("sort_grant_bank", sort_bank, exp_bank);
    check("sort_grant_n", sort_n, exp_n);
    sort_await = 0;
    sort_emit = 1;
    tick();
    sort_emit = 0;
  endtask

  task automatic do_drain(input int exp_bank, input int exp_n);
    int k = 0;
    drain_req = 1;
    tick();
    while (drain_gnt !== 1'b1 && k < 30) begin tick(); k++; end
    check("drain_grant_seen", drain_gnt, 1);
    check("drain_grant_bank", drain_bank, exp_bank);
    check("drain_grant_n", drain_n, exp_n);
    drain_req = 0;
    drain_done = 1;
    tick();
    drain_done = 0;
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    model_reset();
    @(negedge clk);
    do_reset();
    check("reset_err", err, 0);
    check("reset_fill_gnt", fill_gnt, 0);

    // Single job: one-cycle grant latency, N reaches the core
    fill_req = 1;
    tick();
    check("s1_fill_gnt", fill_gnt, 1);
    check("s1_fill_bank", fill_bank, 0);
    fill_req = 0;
    fill_n = 8'd5; fill_done = 1;
    tick();
    fill_done = 0;
    sort_await = 1;
    tick();
    check("s1_sort_gnt", sort_gnt, 1);
    check("s1_sort_bank", sort_bank, 0);
    check("s1_sort_n", sort_n, 5);
    sort_await = 0;

    // Three jobs through two banks; third fill waits for bank 0 to drain
    do_reset();
    do_fill(3, 0, 1);
    do_fill(4, 1, 1);
    fill_req = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("s2_fill_withheld", fill_gnt, 0);
    end
    fill_req = 0;
    do_sort(0, 3);
    do_sort(1, 4);
    do_drain(0, 3);
    do_fill(7, 0, 1);
    do_sort(0, 7);
    do_drain(1, 4);
    do_drain(0, 7);

    // Emit with drain_req already high, plus fill_done on the other bank in the same cycle
    do_reset();
    do_fill(6, 0, 1);
    fill_req = 1;
    tick();
    check("s4_fill1_gnt", fill_gnt, 1);
    fill_req = 0;
    sort_await = 1;
    tick();
    check("s4_sort_gnt", sort_gnt, 1);
    sort_await = 0;
    drain_req = 1;
    tick();
    sort_emit = 1; fill_done = 1; fill_n = 8'd11;
    tick();
    sort_emit = 0; fill_done = 0;
    check("s4_drain_t1", drain_gnt, 0);
    tick();
    check("s4_drain_t2", drain_gnt, 1);
    check("s4_drain_bank", drain_bank, 0);
    check("s4_drain_n", drain_n, 6);
    drain_req = 0;
    do_sort(1, 11);

    // Randomized legal traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      fill_req   = ($urandom_range(0, 3) != 0);
      fill_done  = (m_f > m_fd) && ($urandom_range(0, 3) == 0);
      fill_n     = NW'($urandom);
      sort_await = ($urandom_range(0, 3) != 0);
      sort_emit  = (m_s > m_sd) && ($urandom_range(0, 3) == 0);
      drain_req  = ($urandom_range(0, 3) != 0);
      drain_done = (m_d > m_dd) && ($urandom_range(0, 3) == 0);
      tick();
    end
    clear_inputs();

    // Completion strobes with no bank in flight set the sticky error
    for (int k = 0; k < 3; k++) begin
      do_reset();
      case (k)
        0: sort_emit = 1;
        1: fill_done = 1;
        default: drain_done = 1;
      endcase
      tick();
      clear_inputs();
      check("s5_err_set", err, 1);
      for (int i = 0; i < 3; i++) tick();
      check("s5_err_sticky", err, 1);
    end

    // Reset with bank0 SORTING and bank1 FILLING
    do_reset();
    do_fill(9, 0, 1);
    fill_req = 1; sort_await = 1;
    tick();
    fill_req = 0; sort_await = 0;
    check("s6_fill1_gnt", fill_gnt, 1);
    check("s6_sort_gnt", sort_gnt, 1);
    tick();
    do_reset();
    check("s6_rst_sort_n", sort_n, 0);
    check("s6_rst_fill_bank", fill_bank, 0);
    do_fill(2, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
